// File: rtl/joy_sega_pkg.sv
// Shared state encoding, button bit positions and DB9 pin positions for the Sega pad scanner.
package joy_sega_pkg;

  typedef enum logic [3:0] {
    ST_GAP,
    ST_P0,
    ST_P1,
    ST_P2,
    ST_P3,
    ST_P4,
    ST_P5,
    ST_P6,
    ST_P7
  } state_e;

  localparam int JOY_W = 12;
  localparam int PIN_W = 6;

  localparam int BIT_U = 0;
  localparam int BIT_D = 1;
  localparam int BIT_L = 2;
  localparam int BIT_R = 3;
  localparam int BIT_B = 4;
  localparam int BIT_C = 5;
  localparam int BIT_A = 6;
  localparam int BIT_S = 7;
  localparam int BIT_Z = 8;
  localparam int BIT_Y = 9;
  localparam int BIT_X = 10;
  localparam int BIT_M = 11;

  localparam int PIN_UP    = 0;
  localparam int PIN_DOWN  = 1;
  localparam int PIN_LEFT  = 2;
  localparam int PIN_RIGHT = 3;
  localparam int PIN_P6    = 4;
  localparam int PIN_P9    = 5;

  // Select is driven low on the even phases and idles high everywhere else.
  function automatic logic sel_level(state_e s);
    logic lvl;
    lvl = 1'b1;
    case (s)
      ST_P0, ST_P2, ST_P4, ST_P6: lvl = 1'b0;
      default:                    lvl = 1'b1;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/joy_sega_tick.sv
// Free-running prescaler: one-cycle tick_o every DIV clocks, counter exposed on cnt_o.
module joy_sega_tick #(
  parameter int DIV = 256
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  output logic                   tick_o,
  output logic [$clog2(DIV)-1:0] cnt_o
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/joy_sega_scan.sv
// Sega 3/6-button and SMS pad scanner sharing one select line across NUM_PORTS DB9 ports.
// Define JOY_SEGA_SIXBTN_EN to run the extended P4..P7 phases that read the six-button MXYZ bank.
module joy_sega_scan
  import joy_sega_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int PHASE_CLKS = 256,
  parameter int GAP_PHASES = 64
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [6*NUM_PORTS-1:0]    joy_pins_i,
  output logic                      sel_o,
  output logic [12*NUM_PORTS-1:0]   joy_o,
  output logic [NUM_PORTS-1:0]      six_o,
  output logic                      scan_done_o
);

  localparam int GW = $clog2(GAP_PHASES);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_PHASES - 1);
  localparam int PW = $clog2(PHASE_CLKS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PHASE_CLKS - 1);

`ifdef JOY_SEGA_SIXBTN_EN
  localparam state_e LAST_PHASE = ST_P7;
`else
  localparam state_e LAST_PHASE = ST_P3;
`endif

  logic                                tick;
  logic [PW-1:0]                       presc_cnt;
  logic [NUM_PORTS-1:0][PIN_W-1:0]     pins;

  state_e                              state_q, state_d;
  logic [GW-1:0]                       gap_q, gap_d;
  logic [NUM_PORTS-1:0][JOY_W-1:0]     shadow_q, shadow_d;
  logic [NUM_PORTS-1:0]                six_flag_q, six_flag_d;
  logic [NUM_PORTS-1:0][JOY_W-1:0]     joy_q, joy_d;
  logic [NUM_PORTS-1:0]                six_q, six_d;
  logic                                done_q, done_d;
  logic                                sel_q, sel_d;

  joy_sega_tick #(
    .DIV (PHASE_CLKS)
  ) u_tick (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .tick_o  (tick),
    .cnt_o   (presc_cnt)
  );

  assign pins = joy_pins_i;

  // Pins are captured on the tick that closes a phase, so they have had a full phase to settle.
  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    shadow_d   = shadow_q;
    six_flag_d = six_flag_q;
    joy_d      = joy_q;
    six_d      = six_q;
    done_d     = 1'b0;

    if (tick) begin
      case (state_q)
        ST_P1: begin
          for (int p = 0; p < NUM_PORTS; p++) begin
            shadow_d[p][BIT_U] = pins[p][PIN_UP];
            shadow_d[p][BIT_D] = pins[p][PIN_DOWN];
            shadow_d[p][BIT_L] = pins[p][PIN_LEFT];
            shadow_d[p][BIT_R] = pins[p][PIN_RIGHT];
            shadow_d[p][BIT_B] = pins[p][PIN_P6];
            shadow_d[p][BIT_C] = pins[p][PIN_P9];
          end
        end
        ST_P2: begin
          for (int p = 0; p < NUM_PORTS; p++) begin
            if (!pins[p][PIN_RIGHT] && !pins[p][PIN_LEFT]) begin
              shadow_d[p][BIT_A] = pins[p][PIN_P6];
              shadow_d[p][BIT_S] = pins[p][PIN_P9];
            end else begin
              shadow_d[p][BIT_A] = 1'b1;
              shadow_d[p][BIT_S] = 1'b1;
            end
          end
        end
`ifdef JOY_SEGA_SIXBTN_EN
        ST_P4: begin
          for (int p = 0; p < NUM_PORTS; p++) begin
            six_flag_d[p] = !(pins[p][PIN_UP] | pins[p][PIN_DOWN] |
                              pins[p][PIN_LEFT] | pins[p][PIN_RIGHT]);
          end
        end
        ST_P5: begin
          for (int p = 0; p < NUM_PORTS; p++) begin
            if (six_flag_q[p]) begin
              shadow_d[p][BIT_M] = pins[p][PIN_RIGHT];
              shadow_d[p][BIT_X] = pins[p][PIN_LEFT];
              shadow_d[p][BIT_Y] = pins[p][PIN_DOWN];
              shadow_d[p][BIT_Z] = pins[p][PIN_UP];
            end else begin
              shadow_d[p][BIT_M] = 1'b1;
              shadow_d[p][BIT_X] = 1'b1;
              shadow_d[p][BIT_Y] = 1'b1;
              shadow_d[p][BIT_Z] = 1'b1;
            end
          end
        end
`endif
        default: ;
      endcase

      if (state_q == ST_GAP) begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = ST_P0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end else if (state_q == LAST_PHASE) begin
        joy_d   = shadow_q;
        six_d   = six_flag_q;
        done_d  = 1'b1;
        state_d = ST_GAP;
      end else begin
        state_d = state_e'(state_q + 4'd1);
      end
    end

    sel_d = sel_level(state_d);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_GAP;
      gap_q      <= '0;
      shadow_q   <= '1;
      six_flag_q <= '0;
      joy_q      <= '1;
      six_q      <= '0;
      done_q     <= 1'b0;
      sel_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      shadow_q   <= shadow_d;
      six_flag_q <= six_flag_d;
      joy_q      <= joy_d;
      six_q      <= six_d;
      done_q     <= done_d;
      sel_q      <= sel_d;
    end
  end

  // Phase boundaries must line up with the prescaler wrap.
  always_ff @(posedge clk_i) begin
    if (!reset_i && tick) assert (presc_cnt == PRESC_LAST);
  end

  assign sel_o       = sel_q;
  assign joy_o       = joy_q;
  assign six_o       = six_q;
  assign scan_done_o = done_q;

endmodule

// File: doc/joy_sega_scan.md
JOY_SEGA_SCAN -- requirements
Module: joy_sega_scan

Interface
REQ-001 The module SHALL have parameter NUM_PORTS, default 2, number of DB9 ports sharing one select line (legal 1..4).
REQ-002 The module SHALL have parameter PHASE_CLKS, default 256, clk_i cycles per select phase (legal 16..65535).
REQ-003 The module SHALL have parameter GAP_PHASES, default 64, idle phases with select high between scans (legal 8..1023).
REQ-004 The module SHALL have port clk_i, input, 1, system clock; there is one clock and all logic is on its rising edge.
REQ-005 The module SHALL have port reset_i, input, 1, reset; reset is synchronous and active-high.
REQ-006 The module SHALL have port joy_pins_i, input, 6*NUM_PORTS, raw active-low pins per port {p9,p6,right,left,down,up}, port n at [6n+5:6n].
REQ-007 The module SHALL have port sel_o, input-to-pad select (DB9 pin 7), output, 1, shared select line.
REQ-008 The module SHALL have port joy_o, output, 12*NUM_PORTS, active-low buttons per port, format MXYZ SACB RLDU, port n at [12n+11:12n].
REQ-009 The module SHALL have port six_o, output, NUM_PORTS, 1 when the port was detected as six-button in the last scan.
REQ-010 The module SHALL have port scan_done_o, output, 1, one-cycle pulse when joy_o/six_o update.

Function
REQ-011 A prescaler SHALL assert an internal phase tick every PHASE_CLKS cycles; all state changes except the prescaler occur only on a tick.
REQ-012 The FSM SHALL have states GAP, then phases P0..P7; sel_o SHALL be 0 in P0,P2,P4,P6 and 1 in P1,P3,P5,P7 and GAP.
REQ-013 The pins SHALL be sampled on the tick that ends a phase, i.e. at least PHASE_CLKS-1 cycles after sel_o changed.
REQ-014 At the end of P1, the FSM SHALL capture RLDU from the pins and {C,B} from {p9,p6} into a shadow register per port.
REQ-015 At the end of P2, if right and left are both 0, it SHALL capture {S,A} from {p9,p6}; otherwise it SHALL capture {S,A}=11 (Master System pad).
REQ-016 At the end of P4, the six-button flag for a port SHALL be set iff up, down, left and right are all 0, and cleared otherwise.
REQ-017 At the end of P5, ports with the flag set SHALL capture {M,X,Y,Z} from {right,left,down,up}; ports without it SHALL load 1111.
REQ-018 At the end of P7, the shadow registers SHALL copy to joy_o and six_o in one cycle, scan_done_o SHALL pulse, and the FSM SHALL enter GAP.
REQ-019 GAP SHALL last exactly GAP_PHASES ticks, then the FSM SHALL return to P0; scan period = (8+GAP_PHASES)*PHASE_CLKS cycles.
REQ-020 joy_o and six_o SHALL never show a partially updated scan.
REQ-021 A disconnected port (all pins pulled high) SHALL read joy_o = 12'hFFF and six_o = 0.
REQ-022 Ports SHALL be decoded independently; a mix of 3-button, 6-button and SMS pads on the same select line SHALL be valid.

Reset
REQ-023 While reset_i is 1, the FSM SHALL be in GAP with the gap count at 0, the prescaler at 0, sel_o=1, joy_o all 1, six_o all 0, scan_done_o=0, and the shadow registers all 1.
REQ-024 Reset asserted mid-scan SHALL discard that scan, with no scan_done_o pulse; the first scan after release SHALL start after a full GAP.

Configuration
REQ-025 With macro JOY_SEGA_SIXBTN_EN defined, the FSM SHALL run P0..P7 as specified.
REQ-026 Without JOY_SEGA_SIXBTN_EN, the FSM SHALL run P0..P3 only, and the update of REQ-018 SHALL occur at the end of P3.
REQ-027 Without JOY_SEGA_SIXBTN_EN, bits [11:8] SHALL be 1111 and six_o SHALL be 0.

Structure
REQ-028 Package joy_sega_pkg SHALL hold the FSM state enum, the bit-index constants (U=0,D=1,L=2,R=3,B=4,C=5,A=6,S=7,Z=8,Y=9,X=10,M=11) and the pin-index constants.
REQ-029 The prescaler SHALL be sub-module joy_sega_tick, parameter DIV, with outputs tick_o, a one-cycle pulse, and a counter of width $clog2(DIV).

Verification
REQ-030 With NUM_PORTS=2, PHASE_CLKS=16, GAP_PHASES=8, a 3-button pad model on port 0 with A and Up pressed SHALL give joy_o[11:0]=12'hFBE and six_o[0]=0 after the second scan_done_o.
REQ-031 A 6-button pad model on port 1 with X and Start pressed SHALL give joy_o[23:12]=12'hB7F and six_o[1]=1; port 0 floating SHALL read 12'hFFF.
REQ-032 An SMS pad (right/left never low together) with button 1 pressed SHALL give [7:0]=8'hEF and [11:8]=4'hF.
REQ-033 Measuring sel_o SHALL show a 4-pulse low pattern, each phase 16 cycles, with a period of 256 cycles; scan_done_o SHALL occur once per period.
REQ-034 Reset asserted during P3 and held 3 cycles SHALL give no scan_done_o, joy_o=all 1, and P0 beginning 128 cycles after release.
REQ-035 A build without JOY_SEGA_SIXBTN_EN driving the 6-button model SHALL give six_o=0, [11:8]=4'hF, and a scan period of 192 cycles.
